// File: rtl/csa_resolve_pipe.sv
// Resolves redundant sum/carry vectors into a binary sum, one CHUNK-bit slice per stage.
// Latency STAGES cycles; the whole pipe advances or holds together on !out_valid | out_ready.
module csa_resolve_pipe #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             adv;
    logic             vld_d   [STAGES];
    logic             vld_q   [STAGES];
    logic             cy_d    [STAGES];
    logic             cy_q    [STAGES];
    logic [WIDTH-1:0] res_d   [STAGES];
    logic [WIDTH-1:0] res_q   [STAGES];
    logic [WIDTH-1:0] opa_d   [STAGES];
    logic [WIDTH-1:0] opa_q   [STAGES];
    logic [WIDTH-1:0] opb_d   [STAGES];
    logic [WIDTH-1:0] opb_q   [STAGES];
    logic [CHUNK:0]   slice_sum [STAGES];

    always_comb begin
        adv = !vld_q[STAGES-1] || out_ready;
        for (int s = 0; s < STAGES; s++) begin
            vld_d[s]     = vld_q[s];
            cy_d[s]      = cy_q[s];
            res_d[s]     = res_q[s];
            opa_d[s]     = opa_q[s];
            opb_d[s]     = opb_q[s];
            slice_sum[s] = '0;
        end

        // Unconsumed operand chunks are kept shifted down, so each stage always adds bits [CHUNK-1:0].
        slice_sum[0] = {1'b0, in_sum[CHUNK-1:0]} + {1'b0, in_carry[CHUNK-1:0]};
        for (int s = 1; s < STAGES; s++) begin
            slice_sum[s] = {1'b0, opa_q[s-1][CHUNK-1:0]} + {1'b0, opb_q[s-1][CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, cy_q[s-1]};
        end

        if (adv) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                res_d[0]            = '0;
                res_d[0][CHUNK-1:0] = slice_sum[0][CHUNK-1:0];
                cy_d[0]             = slice_sum[0][CHUNK];
                opa_d[0]            = in_sum >> CHUNK;
                opb_d[0]            = in_carry >> CHUNK;
            end
            // Data registers only load behind a valid slot so outputs keep their last value across bubbles.
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
                if (vld_q[s-1]) begin
                    res_d[s]                    = res_q[s-1];
                    res_d[s][s*CHUNK +: CHUNK]  = slice_sum[s][CHUNK-1:0];
                    cy_d[s]                     = slice_sum[s][CHUNK];
                    opa_d[s]                    = opa_q[s-1] >> CHUNK;
                    opb_d[s]                    = opb_q[s-1] >> CHUNK;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s] <= 1'b0;
                cy_q[s]  <= 1'b0;
                res_q[s] <= '0;
                opa_q[s] <= '0;
                opb_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s] <= vld_d[s];
                cy_q[s]  <= cy_d[s];
                res_q[s] <= res_d[s];
                opa_q[s] <= opa_d[s];
                opb_q[s] <= opb_d[s];
            end
        end
    end

    assign in_ready   = adv;
    assign out_valid  = vld_q[STAGES-1];
    assign out_result = res_q[STAGES-1];
    assign out_cout   = cy_q[STAGES-1];

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Randomized and directed bench for csa_resolve_pipe against a slot-array model using plain addition.
module tb_csa_resolve_pipe;

    localparam int W  = 128;
    localparam int ST = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_sum;
    logic [W-1:0]   in_carry;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_result;
    logic           out_cout;

    logic           v64_in_valid;
    logic           v64_in_ready;
    logic [63:0]    v64_in_sum;
    logic [63:0]    v64_in_carry;
    logic           v64_out_valid;
    logic [63:0]    v64_out_result;
    logic           v64_out_cout;

    always #5 clk = ~clk;

    csa_resolve_pipe #(.WIDTH(W), .CHUNK(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cout(out_cout)
    );

    csa_resolve_pipe #(.WIDTH(64), .CHUNK(16)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v64_in_valid), .in_ready(v64_in_ready),
        .in_sum(v64_in_sum), .in_carry(v64_in_carry),
        .out_valid(v64_out_valid), .out_ready(1'b1),
        .out_result(v64_out_result), .out_cout(v64_out_cout)
    );

    // Model: one slot per pipeline position holding the full-precision sum; the result
    // port shows the last sum that reached the output position.
    logic         m_v   [ST];
    logic [W:0]   m_val [ST];
    logic [W:0]   m_last;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic adv;
        adv = !m_v[ST-1] || out_ready;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < ST; i++) begin
                m_v[i]   = 1'b0;
                m_val[i] = '0;
            end
            m_last = '0;
        end else if (adv) begin
            for (int i = ST-1; i > 0; i--) begin
                m_v[i]   = m_v[i-1];
                m_val[i] = m_val[i-1];
            end
            m_v[0]   = in_valid;
            m_val[0] = {1'b0, in_sum} + {1'b0, in_carry};
            if (m_v[ST-1]) m_last = m_val[ST-1];
        end
        #1;
        check_eq("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, m_v[ST-1]});
        check_eq("in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, (!m_v[ST-1] || out_ready)});
        check_eq("out_result", {1'b0, out_result}, {1'b0, m_last[W-1:0]});
        check_eq("out_cout", {{W{1'b0}}, out_cout}, {{W{1'b0}}, m_last[W]});
    endtask

    task automatic drive(input logic v, input logic [W-1:0] s, input logic [W-1:0] c);
        in_valid = v;
        in_sum   = s;
        in_carry = c;
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom % 4)
            0: w = '1;
            1: w = w >> ($urandom % W);
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W-1:0] one;

        for (int i = 0; i < ST; i++) begin
            m_v[i]   = 1'b0;
            m_val[i] = '0;
        end
        m_last       = '0;
        one          = 1;
        rst_n        = 1'b0;
        out_ready    = 1'b1;
        v64_in_valid = 1'b0;
        v64_in_sum   = '0;
        v64_in_carry = '0;
        drive(1'b0, '0, '0);

        // Reset state
        step();
        step();
        check_eq("rst_in_ready", {{W{1'b0}}, in_ready}, 129'd1);
        rst_n = 1'b1;
        step();

        // Full ripple from bit 0 to the carry out
        drive(1'b1, '1, one);
        step();
        drive(1'b0, '0, '0);
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check_eq("ripple_lat", lat, ST);
        check_eq("ripple_res", {1'b0, out_result}, 129'd0);
        check_eq("ripple_cout", {{W{1'b0}}, out_cout}, 129'd1);
        step();

        // Streaming, known answers on consecutive cycles
        drive(1'b1, W'(5), W'(7));                 step();
        drive(1'b1, one << 64, one << 64);         step();
        drive(1'b1, one << 127, one << 127);       step();
        drive(1'b1, W'(32'h1234_5678), W'(32'hEDCB_A988)); step();
        drive(1'b0, '0, '0);
        check_eq("stream0", {out_cout, out_result}, 129'd12);
        step();
        check_eq("stream1", {out_cout, out_result}, {1'b0, one << 65});
        step();
        check_eq("stream2", {out_cout, out_result}, {1'b1, {W{1'b0}}});
        step();
        check_eq("stream3", {out_cout, out_result}, 129'h1_0000_0000);
        step();

        // Backpressure with a held input pair
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rnd_word(), rnd_word());
            step();
        end
        drive(1'b1, W'(1000), W'(234));
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_in_ready", {{W{1'b0}}, in_ready}, 129'd0);
        end
        out_ready = 1'b1;
        step();
        drive(1'b0, '0, '0);
        for (int i = 0; i < 6; i++) step();
        check_eq("bp_held_pair", {out_cout, out_result}, 129'd1234);

        // Bubbles
        for (int i = 0; i < 6; i++) begin
            drive(i % 2 == 0, rnd_word(), rnd_word());
            step();
        end
        drive(1'b0, '0, '0);
        for (int i = 0; i < 5; i++) step();

        // Reset mid-flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd_word(), rnd_word());
            step();
        end
        drive(1'b0, '0, '0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("rst_mid_valid", {{W{1'b0}}, out_valid}, 129'd0);
        for (int i = 0; i < 6; i++) step();
        drive(1'b1, one, one);
        step();
        drive(1'b0, '0, '0);
        for (int i = 0; i < 3; i++) step();
        check_eq("post_rst_valid", {{W{1'b0}}, out_valid}, 129'd1);
        check_eq("post_rst_res", {out_cout, out_result}, 129'd2);

        // Random traffic with biased carry chains
        for (int i = 0; i < 400; i++) begin
            s = rnd_word();
            c = ($urandom % 3 == 0) ? (~s + W'($urandom % 3)) : rnd_word();
            drive(($urandom % 4) != 0, s, c);
            out_ready = ($urandom % 3) != 0;
            step();
        end
        out_ready = 1'b1;
        drive(1'b0, '0, '0);
        for (int i = 0; i < 6; i++) step();

        // 64-bit / 16-bit chunk instance
        v64_in_valid = 1'b1;
        v64_in_sum   = 64'h0000_FFFF_FFFF_FFFF;
        v64_in_carry = 64'h1;
        step();
        v64_in_valid = 1'b0;
        v64_in_sum   = '0;
        v64_in_carry = '0;
        step();
        step();
        check_eq("w64_not_early", {{W{1'b0}}, v64_out_valid}, 129'd0);
        step();
        check_eq("w64_valid", {{W{1'b0}}, v64_out_valid}, 129'd1);
        check_eq("w64_res", {65'd0, v64_out_result}, {65'd0, 64'h0001_0000_0000_0000});
        check_eq("w64_cout", {{W{1'b0}}, v64_out_cout}, 129'd0);
        step();
        check_eq("w64_drain", {{W{1'b0}}, v64_out_valid}, 129'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
